perf_event_counter: RTL
=======================

Name: perf_event_counter

Overview:
Synthesizable, parametrised successor to the bench-side cycle, stall and flush counting used around the pipelined CPU. It counts clock cycles plus NUM_EVENTS independent single-bit pipeline events (stall, flush, retire, …) over a programmable cycle window. Results are exposed through a registered read port. It sits beside the CPU top, fed by hazard/control strobes, and is readable by the bench or a future debug bus.

Parameters:
NUM_EVENTS, 4, number of event inputs/counters (1..16)
CNT_W, 32, width of cycle counter and each event counter
LIMIT_W, 16, width of the cycle-window limit
SEL_W, $clog2(NUM_EVENTS+1), width of read select (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  begin counting window (sampled in IDLE only)
clear_i  in  1  synchronous clear of all counters/flags, return to IDLE
freeze_i  in  1  pause counting while high (state unchanged)
limit_i  in  LIMIT_W  window length in counted cycles; 0 = unlimited; latched on start
event_i  in  NUM_EVENTS  per-cycle event strobes, bit k -> counter k
rd_sel_i  in  SEL_W  0 = cycle counter, k = event counter k-1
rd_data_o  out  CNT_W  registered read data
running_o  out  1  high in RUN
done_o  out  1  high in DONE
ovf_o  out  NUM_EVENTS+1  sticky saturation flags, bit 0 = cycle, bit k = event k-1

Behaviour:
- Reset (async, rst_i=1): state IDLE; all counters, ovf_o, rd_data_o, limit register = 0; running_o=0, done_o=0.
- States: IDLE, RUN, DONE (running_o/done_o decoded from registered state).
- IDLE: start_i=1 -> RUN next edge; limit_i latched same edge. No counting in IDLE.
- RUN: each edge with freeze_i=0: cycle counter +1; event counter k +1 if event_i[k]=1. freeze_i=1 -> nothing changes.
- RUN -> DONE on the edge where the new cycle count equals latched limit (limit != 0). limit=N yields exactly N counted cycles; events sampled on that final edge are counted.
- limit=0: stays in RUN until clear_i.
- DONE: counters hold; start_i, freeze_i and event_i ignored.
- start_i in RUN/DONE ignored (no restart without clear).
- clear_i: highest priority over start/freeze/events in any state; next edge: IDLE, counters and ovf_o = 0, limit register = 0. rd_data_o updates normally (reflects cleared values one cycle later).
- Saturation: counter at all-ones does not wrap; an increment attempt sets its ovf_o bit, sticky until clear/reset.
- Read: rd_data_o <= selected counter value as of the current edge's pre-update contents; latency 1 cycle. rd_sel_i > NUM_EVENTS -> 0.
- Reset asserted mid-RUN: immediate return to reset values; no partial state retained.

Optional Feature:
PERF_SNAPSHOT_EN
- Defined: adds input snap_i (1 bit) and shadow registers for all NUM_EVENTS+1 counters. The shadows capture live values on a snap_i edge (ignored if clear_i) and automatically on the RUN->DONE edge. The read port returns shadow values; live counting is unaffected. Shadows are cleared by reset/clear_i.
- Undefined: no snap_i port, no shadow storage; the read port returns live counters.

Decomposition:
- Shared package perf_pkg: state enum (IDLE/RUN/DONE), read-select constant SEL_CYCLE=0, saturation max-value helper.
- One natural sub-module: perf_sat_counter (CNT_W-wide saturating counter with inc, clr and sticky ovf). Instantiated NUM_EVENTS+1 times via generate.

Test Plan:
- Reset then limit_i=5, start_i 1 cycle, event_i[0]=1 every cycle -> done_o after 5 counted cycles; sel0 reads 5, sel1 reads 5, sel2 reads 0; running_o low after DONE.
- limit_i=10, freeze_i high for cycles 3-6 of the window, event_i[1] toggling -> DONE entry delayed 4 cycles; cycle count 10; event1 count = number of unfrozen high samples.
- CNT_W=4, limit_i=0, event_i[2]=1 for 20 cycles -> counter 3 reads 15, ovf_o[3]=1, ovf_o[0]=1; no wrap.
- clear_i asserted simultaneously with start_i in IDLE, and mid-RUN -> state IDLE, all reads 0, ovf_o=0; start next cycle begins a fresh window.
- rst_i pulsed asynchronously mid-RUN (between edges) -> outputs zero immediately, before the next clock edge; rd_sel_i=7 with NUM_EVENTS=4 -> rd_data_o=0.
- With PERF_SNAPSHOT_EN: snap_i at cycle count 3 of a limit=8 window -> sel0 reads 3 until DONE, then 8.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and helpers for the performance event counter block.
// Holds the window state encoding, the read-select index of the cycle counter and the saturation limit.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Read-select / counter index of the free cycle counter; events follow at 1..NUM_EVENTS.
    localparam int SEL_CYCLE = 0;

    function automatic logic [63:0] sat_max(input int unsigned width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
// An increment at all-ones holds the value and raises ovf until clr or rst.
module perf_sat_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (cnt == CNT_MAX) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_event_counter.sv
// Cycle + per-event counters over a programmable window, read through a one-cycle registered port.
// Optional PERF_SNAPSHOT_EN adds snap_i and shadow copies that the read port returns instead of live counts.
module perf_event_counter
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_W      = 32,
    parameter int LIMIT_W    = 16,
    parameter int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic                  freeze_i,
    input  logic [LIMIT_W-1:0]    limit_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [SEL_W-1:0]      rd_sel_i,
`ifdef PERF_SNAPSHOT_EN
    input  logic                  snap_i,
`endif
    output logic [CNT_W-1:0]      rd_data_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic [NUM_EVENTS:0]   ovf_o
);

    localparam int NUM_CNT = NUM_EVENTS + 1;
    localparam int CMP_W   = (CNT_W > LIMIT_W) ? CNT_W : LIMIT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    state_t               state;
    state_t               state_nxt;
    logic [LIMIT_W-1:0]   limit_q;
    logic                 count_en;
    logic                 win_end;
    logic [NUM_CNT-1:0]   inc;
    logic [CNT_W-1:0]     live   [NUM_CNT];
    logic [CNT_W-1:0]     rd_src [NUM_CNT];
    logic [CNT_W-1:0]     rd_mux;

    assign count_en = (state == RUN) && !freeze_i && !clear_i;

    // A saturated cycle counter can never reach the limit, so the window then runs until clear.
    assign win_end = count_en
                  && (limit_q != '0)
                  && (live[SEL_CYCLE] != CNT_MAX)
                  && ((CMP_W'(live[SEL_CYCLE]) + CMP_W'(1)) == CMP_W'(limit_q));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_i) state_nxt = RUN;
                RUN:     if (win_end) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            limit_q <= '0;
        end else if (clear_i) begin
            limit_q <= '0;
        end else if ((state == IDLE) && start_i) begin
            limit_q <= limit_i;
        end
    end

    always_comb begin
        inc = '0;
        inc[SEL_CYCLE] = count_en;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            inc[k + 1] = count_en & event_i[k];
        end
    end

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        perf_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk (clk_i),
            .rst (rst_i),
            .clr (clear_i),
            .inc (inc[k]),
            .cnt (live[k]),
            .ovf (ovf_o[k])
        );
    end

`ifdef PERF_SNAPSHOT_EN
    // Shadows take the post-edge value so a capture on the final window edge holds the closing totals.
    for (genvar k = 0; k < NUM_CNT; k++) begin : g_shadow
        logic [CNT_W-1:0] shadow;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                shadow <= '0;
            end else if (clear_i) begin
                shadow <= '0;
            end else if (snap_i || win_end) begin
                shadow <= (inc[k] && (live[k] != CNT_MAX)) ? live[k] + CNT_W'(1) : live[k];
            end
        end

        assign rd_src[k] = shadow;
    end
`else
    for (genvar k = 0; k < NUM_CNT; k++) begin : g_live_rd
        assign rd_src[k] = live[k];
    end
`endif

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (rd_sel_i == SEL_W'(k)) begin
                rd_mux = rd_src[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= rd_mux;
        end
    end

    assign running_o = (state == RUN);
    assign done_o    = (state == DONE);

endmodule
